// File: rtl/ksa_pkg.sv
// ksa_pkg: shared helpers and defaults for the pipelined Kogge-Stone adder.
//   ksa_clog2(n)          : ceil(log2(n)), number of prefix levels for n bits
//   ksa_latency(w, s)     : accept-to-output latency in cycles, 1 + ceil(L/s)
//   DEF_WIDTH, DEF_PIPE_STRIDE : default parameter values for ksa_pipe_adder
package ksa_pkg;

   localparam int unsigned DEF_WIDTH       = 16;
   localparam int unsigned DEF_PIPE_STRIDE = 1;

   function automatic int unsigned ksa_clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r++;
      return r;
   endfunction

   function automatic int unsigned ksa_latency(input int unsigned width,
                                               input int unsigned stride);
      int unsigned lv;
      lv = ksa_clog2(width);
      return 1 + (lv + stride - 1) / stride;
   endfunction

endpackage

// File: rtl/ksa_prefix_cell.sv
// ksa_prefix_cell: Kogge-Stone black cell, combines (g,p) of position i
// with (g,p) of position i-2^k.
//   gi, pi : generate/propagate of the more significant span
//   gj, pj : generate/propagate of the less significant span
//   go, po : combined generate/propagate
module ksa_prefix_cell
   import ksa_pkg::*;
(
   input  logic gi,
   input  logic pi,
   input  logic gj,
   input  logic pj,
   output logic go,
   output logic po
);

   assign go = gi | (pi & gj);
   assign po = pi & pj;

endmodule

// File: rtl/ksa_pipe_adder.sv
// ksa_pipe_adder: pipelined Kogge-Stone adder/subtractor with valid/ready.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operand handshake
//   a, b, cin, sub      : operands; sub=1 computes a-b (cin ignored)
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result, carry-out (1 = no borrow on sub), signed overflow
// Latency is 1 + ceil(clog2(WIDTH)/PIPE_STRIDE) cycles; the whole pipe
// advances together (no bubble compression), so results keep input order.
module ksa_pipe_adder
   import ksa_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned PIPE_STRIDE = DEF_PIPE_STRIDE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned L  = ksa_clog2(WIDTH);
   localparam int unsigned NS = (L + PIPE_STRIDE - 1) / PIPE_STRIDE;

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Stage 0: operand conditioning, carry-in folded into bit-0 generate.
   logic [WIDTH-1:0] g0, p0;
   logic             c0;
   always_comb begin
      logic [WIDTH-1:0] bb;
      bb    = sub ? ~b : b;
      c0    = sub ? 1'b1 : cin;
      p0    = a ^ bb;
      g0    = a & bb;
      g0[0] = g0[0] | (p0[0] & c0);
   end

   // Stage register j feeds prefix levels j*PIPE_STRIDE onward; stage 0
   // captures the conditioned operands, later ones the last level of the
   // previous group. p and c0 ride along for the final sum.
   genvar j, k, i;
   for (j = 0; j < NS; j++) begin : stg
      logic [WIDTH-1:0] g_d, p_d, pp_d, g_q, p_q, pp_q;
      logic             c0_d, v_d, c0_q, v_q;
      if (j == 0) begin : src
         assign g_d  = g0;
         assign p_d  = p0;
         assign pp_d = p0;
         assign c0_d = c0;
         assign v_d  = in_valid;
      end else begin : src
         assign g_d  = lvl[j*PIPE_STRIDE-1].go;
         assign p_d  = lvl[j*PIPE_STRIDE-1].po;
         assign pp_d = stg[j-1].pp_q;
         assign c0_d = stg[j-1].c0_q;
         assign v_d  = stg[j-1].v_q;
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            g_q  <= '0;
            p_q  <= '0;
            pp_q <= '0;
            c0_q <= 1'b0;
            v_q  <= 1'b0;
         end else if (adv) begin
            g_q  <= g_d;
            p_q  <= p_d;
            pp_q <= pp_d;
            c0_q <= c0_d;
            v_q  <= v_d;
         end
      end
   end

   // Prefix level k: black cell where i >= 2^k, buffer below.
   for (k = 0; k < L; k++) begin : lvl
      localparam int D = 1 << k;
      logic [WIDTH-1:0] gi, pi, go, po;
      if (k % PIPE_STRIDE == 0) begin : src
         assign gi = stg[k/PIPE_STRIDE].g_q;
         assign pi = stg[k/PIPE_STRIDE].p_q;
      end else begin : src
         assign gi = lvl[k-1].go;
         assign pi = lvl[k-1].po;
      end
      for (i = 0; i < WIDTH; i++) begin : gen_bit
         if (i >= D) begin : black
            ksa_prefix_cell u_cell (
               .gi (gi[i]),
               .pi (pi[i]),
               .gj (gi[i-D]),
               .pj (pi[i-D]),
               .go (go[i]),
               .po (po[i])
            );
         end else begin : grey
            assign go[i] = gi[i];
            assign po[i] = pi[i];
         end
      end
   end

   // Group propagate after the last level has no consumer.
   logic unused_po;
   assign unused_po = ^lvl[L-1].po;

   logic [WIDTH-1:0] fin_g, fin_p, sum_d;
   logic             fin_c0;
   assign fin_g  = lvl[L-1].go;
   assign fin_p  = stg[NS-1].pp_q;
   assign fin_c0 = stg[NS-1].c0_q;
   assign sum_d  = fin_p ^ {fin_g[WIDTH-2:0], fin_c0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (adv) begin
         out_valid <= stg[NS-1].v_q;
         sum       <= sum_d;
         cout      <= fin_g[WIDTH-1];
         ovf       <= fin_g[WIDTH-1] ^ fin_g[WIDTH-2];
      end
   end

endmodule
